// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte
// producers, issuing one send strobe per frame and holding off until the line is free.

module uart_tx_arb_lane (
    input  logic       sel,
    input  logic [7:0] data,
    output logic [7:0] data_masked
);
    assign data_masked = sel ? data : 8'h00;
endmodule

module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int CLKS_PER_BIT = 16,
    parameter  int FRAME_BITS   = 10,
    parameter  int GAP_CYCLES   = 0,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   tx_send,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
);
    localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
    localparam int TOTAL        = FRAME_CYCLES + GAP_CYCLES;
    localparam int CNT_W        = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t                   state, state_n;
    logic [ID_W-1:0]          ptr, ptr_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    logic [NUM_REQ-1:0]       ack_n;
    logic                     send_n, busy_n;
    logic [7:0]               data_n;
    logic [ID_W-1:0]          gid_n;

    logic                     win_found;
    logic [ID_W-1:0]          win_idx;
    logic [NUM_REQ-1:0]       win_oh;
    logic [NUM_REQ-1:0][7:0]  req_bytes, masked;
    logic [7:0]               sel_data;

    assign req_bytes = req_data;

    // First set request at or after ptr, wrapping; the last winner ends up lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign win_oh = NUM_REQ'(1) << win_idx;

    uart_tx_arb_lane u_lane [NUM_REQ-1:0] (
        .sel         (win_oh),
        .data        (req_bytes),
        .data_masked (masked)
    );

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) sel_data = sel_data | masked[i];
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        ack_n   = '0;
        send_n  = 1'b0;
        data_n  = tx_data;
        gid_n   = grant_id;
        case (state)
            IDLE: begin
                if (win_found) begin
                    send_n  = 1'b1;
                    ack_n   = win_oh;
                    data_n  = sel_data;
                    gid_n   = win_idx;
                    ptr_n   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                cnt_n   = CNT_W'(1);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_W'(TOTAL - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            ack      <= '0;
            tx_send  <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            ack      <= ack_n;
            tx_send  <= send_n;
            tx_data  <= data_n;
            busy     <= busy_n;
            grant_id <= gid_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Two arbiters (no gap / 5-cycle gap) share stimulus; a busy-countdown model
// predicts every output each cycle, and directed checks pin the model's timing.

module tb_uart_tx_arbiter;
    logic             clock;
    logic             reset;
    logic [3:0]       req;
    logic [31:0]      req_data;
    logic [1:0][3:0]  ack_w;
    logic [1:0]       send_w;
    logic [1:0][7:0]  data_w;
    logic [1:0]       busy_w;
    logic [1:0][1:0]  gid_w;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit started = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack_w[0]), .tx_send(send_w[0]), .tx_data(data_w[0]),
        .busy(busy_w[0]), .grant_id(gid_w[0]));

    uart_tx_arbiter #(.NUM_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CYCLES(5)) dut1 (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack_w[1]), .tx_send(send_w[1]), .tx_data(data_w[1]),
        .busy(busy_w[1]), .grant_id(gid_w[1]));

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Model: a requester wins only when the line has been free for a full sample;
    // left[k] is the number of busy cycles (SEND + WAIT) still ahead.
    int        total [2] = '{40, 45};
    int        left  [2] = '{0, 0};
    int        mptr  [2] = '{0, 0};
    logic [3:0] e_ack [2] = '{4'h0, 4'h0};
    logic       e_send[2] = '{1'b0, 1'b0};
    logic [7:0] e_data[2] = '{8'h00, 8'h00};
    int         e_gid [2] = '{0, 0};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                left[k] = 0; mptr[k] = 0; e_ack[k] = 0; e_send[k] = 0;
                e_data[k] = 0; e_gid[k] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                e_send[k] = 0;
                e_ack[k]  = 0;
                if (left[k] > 0) left[k] = left[k] - 1;
                else if (req != 4'h0) begin
                    int w;
                    w = -1;
                    for (int i = 0; i < 4; i++)
                        if (w < 0 && req[(mptr[k] + i) % 4]) w = (mptr[k] + i) % 4;
                    e_send[k] = 1;
                    e_ack[k]  = 4'(1 << w);
                    e_data[k] = req_data[w*8 +: 8];
                    e_gid[k]  = w;
                    mptr[k]   = (w + 1) % 4;
                    left[k]   = total[k];
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    int send_cyc[2][$];
    int send_dat[2][$];
    int ack_cnt [2] = '{0, 0};

    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_ack%0d", k),  int'(ack_w[k]),  int'(e_ack[k]));
                chk($sformatf("model_send%0d", k), int'(send_w[k]), int'(e_send[k]));
                chk($sformatf("model_data%0d", k), int'(data_w[k]), int'(e_data[k]));
                chk($sformatf("model_busy%0d", k), int'(busy_w[k]), int'(left[k] > 0));
                chk($sformatf("model_gid%0d", k),  int'(gid_w[k]),  e_gid[k]);
                if (send_w[k]) begin
                    send_cyc[k].push_back(cyc);
                    send_dat[k].push_back(int'(data_w[k]));
                end
                if (ack_w[k] != 4'h0) ack_cnt[k]++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            send_cyc[k].delete();
            send_dat[k].delete();
            ack_cnt[k] = 0;
        end
        #1 reset = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_w != 2'b00 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle", int'(busy_w), 0);
    endtask

    // Returns at the negedge where tx_send of instance k is high.
    task automatic wait_send(input int k);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!send_w[k] && n < 100);
        chk($sformatf("send_timeout%0d", k), int'(send_w[k]), 1);
    endtask

    task automatic wait_sends(input int k, input int cnt);
        int n = 0;
        while (send_cyc[k].size() < cnt && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("sends_count%0d", k), send_cyc[k].size() >= cnt ? cnt : send_cyc[k].size(), cnt);
    endtask

    initial begin
        int n;
        reset = 1;
        req = 4'h0;
        req_data = 32'h0;
        repeat (2) @(negedge clock);
        started = 1;
        chk("rst_busy", int'(busy_w), 0);
        chk("rst_send", int'(send_w), 0);
        chk("rst_ack",  int'(ack_w), 0);
        chk("rst_gid",  int'(gid_w), 0);
        chk("rst_data", int'(data_w), 0);
        #1 reset = 0;

        // Single request from requester 1
        @(negedge clock);
        req = 4'b0010;
        req_data[15:8] = 8'hA5;
        wait_send(0);
        req = 4'b0000;
        chk("single_data", int'(data_w[0]), 8'hA5);
        chk("single_ack",  int'(ack_w[0]), 4'b0010);
        chk("single_gid",  int'(gid_w[0]), 1);
        n = 1;
        @(negedge clock);
        while (busy_w[0] && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("single_busy_len", n, 40);
        wait_idle();

        // All four requesting continuously
        do_reset();
        req_data = 32'h43322110;
        req = 4'b1111;
        wait_sends(0, 5);
        req = 4'b0000;
        if (send_cyc[0].size() >= 5) begin
            chk("rr_d0", send_dat[0][0], 8'h10);
            chk("rr_d1", send_dat[0][1], 8'h21);
            chk("rr_d2", send_dat[0][2], 8'h32);
            chk("rr_d3", send_dat[0][3], 8'h43);
            chk("rr_d4", send_dat[0][4], 8'h10);
            for (int i = 1; i < 5; i++)
                chk("rr_spacing", send_cyc[0][i] - send_cyc[0][i-1], 41);
        end
        if (send_cyc[1].size() >= 4) begin
            chk("gap_d3", send_dat[1][3], 8'h43);
            for (int i = 1; i < 4; i++)
                chk("gap_spacing_rr", send_cyc[1][i] - send_cyc[1][i-1], 46);
        end
        wait_idle();

        // Round-robin: 3 granted, then 1001 goes to 0, then to 3
        do_reset();
        req = 4'b1000;
        wait_send(0);
        req = 4'b0000;
        chk("rr3_gid", int'(gid_w[0]), 3);
        wait_idle();
        @(negedge clock);
        req = 4'b1001;
        wait_send(0);
        req = 4'b0000;
        chk("rr_next0", int'(gid_w[0]), 0);
        chk("rr_next0_gap", int'(gid_w[1]), 0);
        wait_idle();
        @(negedge clock);
        req = 4'b1001;
        wait_send(0);
        req = 4'b0000;
        chk("rr_next3", int'(gid_w[0]), 3);
        chk("rr_next3_ack", int'(ack_w[0]), 4'b1000);
        wait_idle();

        // Back-to-back from requester 2 with a mid-frame data change
        do_reset();
        req_data = 32'h0;
        req_data[23:16] = 8'h55;
        req = 4'b0100;
        wait_send(1);
        repeat (10) @(negedge clock);
        req_data[23:16] = 8'h66;
        repeat (5) @(negedge clock);
        chk("hold_data_gap", int'(data_w[1]), 8'h55);
        chk("hold_data", int'(data_w[0]), 8'h55);
        wait_sends(1, 2);
        req = 4'b0000;
        if (send_cyc[1].size() >= 2) begin
            chk("gap_spacing", send_cyc[1][1] - send_cyc[1][0], 46);
            chk("gap_second_data", send_dat[1][1], 8'h66);
        end
        chk("gap_ack_count", ack_cnt[1], 2);
        wait_idle();

        // Reset in the middle of a frame (WAIT counter = 17)
        do_reset();
        req = 4'b0010;
        wait_send(0);
        req = 4'b0000;
        repeat (17) @(negedge clock);
        chk("pre_rst_busy", int'(busy_w[0]), 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_busy", int'(busy_w), 0);
        chk("mid_rst_send", int'(send_w), 0);
        chk("mid_rst_ack",  int'(ack_w), 0);
        chk("mid_rst_gid",  int'(gid_w), 0);
        @(negedge clock);
        reset = 0;
        req = 4'b0100;
        wait_send(0);
        req = 4'b0000;
        chk("post_rst_gid", int'(gid_w[0]), 2);
        chk("post_rst_ack", int'(ack_w[0]), 4'b0100);
        wait_idle();

        // Withdrawn request between sampling edges
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            send_cyc[k].delete();
            ack_cnt[k] = 0;
        end
        #1 req = 4'b0010;
        #2 req = 4'b0000;
        repeat (10) @(negedge clock);
        chk("withdraw_send", send_cyc[0].size(), 0);
        chk("withdraw_ack",  ack_cnt[0], 0);
        chk("withdraw_busy", int'(busy_w), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
